// File: rtl/trng_entropy_responder_if.sv
// Signal bundle between the TRNG responder, its entropy sampler and its requester.
// The master side drives entropy and requests; the slave side is the responder.
interface trng_entropy_responder_if #(
  parameter int WIDTH      = 32,
  parameter int FIFO_DEPTH = 4
);
  logic                               entropy_bit;
  logic                               entropy_valid;
  logic                               trng_request;
  logic [WIDTH-1:0]                   random_number;
  logic                               ready;
  logic                               health_fail;
  logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level;

  modport master (
    output entropy_bit, entropy_valid, trng_request,
    input  random_number, ready, health_fail, fifo_level
  );

  modport slave (
    input  entropy_bit, entropy_valid, trng_request,
    output random_number, ready, health_fail, fifo_level
  );
endinterface

// File: rtl/trng_entropy_responder.sv
// TRNG responder: repetition-count health test, von Neumann debias, word packer,
// small word FIFO and a request/ready delivery FSM.
module trng_entropy_responder #(
  parameter int WIDTH      = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int RUN_LIMIT  = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  trng_entropy_responder_if.slave bus
);
  localparam int LVL_W  = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int RUN_W  = $clog2(RUN_LIMIT + 1);
  localparam int PACK_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, WAIT, DELIVER} state_t;

  state_t           r_state;
  state_t           w_stateNext;
  logic             r_prevBit;
  logic [RUN_W-1:0] r_runCnt;
  logic             r_healthFail;
  logic             r_pairFull;
  logic             r_pairBit;
  logic [WIDTH-1:0] r_packWord;
  logic [PACK_W-1:0] r_packCnt;
  logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_rdPtr;
  logic [PTR_W-1:0] r_wrPtr;
  logic [LVL_W-1:0] r_level;
  logic [WIDTH-1:0] r_randomNumber;

  logic             w_bitIn;
  logic [RUN_W-1:0] w_runNext;
  logic             w_trip;
  logic             w_emit;
  logic             w_wordDone;
  logic [WIDTH-1:0] w_packNext;
  logic             w_push;
  logic             w_pop;

  // A run counter of zero means no valid bit has been seen since reset.
  assign w_bitIn    = bus.entropy_valid && !r_healthFail;
  assign w_runNext  = (r_runCnt != '0 && bus.entropy_bit == r_prevBit) ?
                      r_runCnt + RUN_W'(1) : RUN_W'(1);
  assign w_trip     = w_bitIn && (w_runNext == RUN_W'(RUN_LIMIT));
  assign w_emit     = w_bitIn && r_pairFull && (r_pairBit != bus.entropy_bit);
  assign w_packNext = {r_packWord[WIDTH-2:0], r_pairBit};
  assign w_wordDone = w_emit && (r_packCnt == PACK_W'(WIDTH - 1));
  assign w_push     = w_wordDone && !w_trip && (r_level != LVL_W'(FIFO_DEPTH));

  always_comb begin
    w_stateNext = r_state;
    w_pop       = 1'b0;
    if (r_healthFail || w_trip) begin
      w_stateNext = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.trng_request) begin
            if (r_level != '0) begin
              w_pop       = 1'b1;
              w_stateNext = DELIVER;
            end else begin
              w_stateNext = WAIT;
            end
          end
        end
        WAIT: begin
          if (r_level != '0) begin
            w_pop       = 1'b1;
            w_stateNext = DELIVER;
          end
        end
        DELIVER: w_stateNext = IDLE;
        default: w_stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= w_packNext;
    end
  end

  // A health trip flushes every partial result along with the FIFO.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_prevBit      <= 1'b0;
      r_runCnt       <= '0;
      r_healthFail   <= 1'b0;
      r_pairFull     <= 1'b0;
      r_pairBit      <= 1'b0;
      r_packWord     <= '0;
      r_packCnt      <= '0;
      r_rdPtr        <= '0;
      r_wrPtr        <= '0;
      r_level        <= '0;
      r_randomNumber <= '0;
    end else begin
      r_state <= w_stateNext;
      if (w_bitIn) begin
        r_prevBit <= bus.entropy_bit;
        r_runCnt  <= w_runNext;
      end
      if (w_trip) begin
        r_healthFail <= 1'b1;
        r_pairFull   <= 1'b0;
        r_packWord   <= '0;
        r_packCnt    <= '0;
        r_rdPtr      <= '0;
        r_wrPtr      <= '0;
        r_level      <= '0;
      end else begin
        if (w_bitIn) begin
          r_pairFull <= !r_pairFull;
          if (!r_pairFull) begin
            r_pairBit <= bus.entropy_bit;
          end
        end
        if (w_emit) begin
          if (w_wordDone) begin
            r_packWord <= '0;
            r_packCnt  <= '0;
          end else begin
            r_packWord <= w_packNext;
            r_packCnt  <= r_packCnt + PACK_W'(1);
          end
        end
        if (w_push) begin
          r_wrPtr <= r_wrPtr + PTR_W'(1);
        end
        if (w_pop) begin
          r_rdPtr        <= r_rdPtr + PTR_W'(1);
          r_randomNumber <= r_mem[r_rdPtr];
        end
        if (w_push && !w_pop) begin
          r_level <= r_level + LVL_W'(1);
        end else if (!w_push && w_pop) begin
          r_level <= r_level - LVL_W'(1);
        end
      end
    end
  end

  assign bus.random_number = r_randomNumber;
  assign bus.ready         = (r_state == DELIVER);
  assign bus.health_fail   = r_healthFail;
  assign bus.fifo_level    = r_level;
endmodule

// File: tb/tb_trng_entropy_responder.sv
// Scoreboard bench for trng_entropy_responder: a transaction-level reference model
// predicts deliveries into a queue that a negedge monitor pops and compares.
module tb_trng_entropy_responder;
  localparam int WIDTH      = 32;
  localparam int FIFO_DEPTH = 4;
  localparam int RUN_LIMIT  = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  trng_entropy_responder_if #(.WIDTH(WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

  trng_entropy_responder #(
    .WIDTH(WIDTH), .FIFO_DEPTH(FIFO_DEPTH), .RUN_LIMIT(RUN_LIMIT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;
  bit monEn = 1'b0;
  bit stopFeed = 1'b0;

  // Reference model state: words are plain queue entries, the packer is a bit count.
  logic [WIDTH-1:0] mFifo[$];
  logic [WIDTH-1:0] expQ[$];
  logic [WIDTH-1:0] mWord = '0;
  logic [WIDTH-1:0] mLastWord = '0;
  bit mFail = 0, mWaiting = 0, mDeliver = 0, mHavePair = 0, mA = 0, mLast = 0;
  int mRunLen = 0, mBits = 0, mSize = 0;
  bit mTrip, mEmit, mPop, mEbit;

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] actual,
                             input logic [WIDTH-1:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      mFifo.delete(); expQ.delete();
      mWord = '0; mLastWord = '0; mBits = 0; mRunLen = 0;
      mFail = 0; mWaiting = 0; mDeliver = 0; mHavePair = 0; mA = 0; mLast = 0;
    end else begin
      mSize = mFifo.size();
      mTrip = 0; mEmit = 0; mEbit = 0;
      if (bus.entropy_valid && !mFail) begin
        mRunLen = (mRunLen > 0 && bus.entropy_bit == mLast) ? mRunLen + 1 : 1;
        mLast = bus.entropy_bit;
        mTrip = (mRunLen == RUN_LIMIT);
        if (!mTrip) begin
          if (!mHavePair) begin
            mHavePair = 1; mA = bus.entropy_bit;
          end else begin
            mHavePair = 0;
            if (mA != bus.entropy_bit) begin mEmit = 1; mEbit = mA; end
          end
        end
      end
      mPop = !mFail && !mTrip && mSize > 0 &&
             (mWaiting || (!mDeliver && bus.trng_request));
      if (mFail || mTrip) mWaiting = 0;
      else if (mWaiting) mWaiting = !mPop;
      else mWaiting = !mDeliver && bus.trng_request && mSize == 0;
      mDeliver = mPop;
      if (mPop) begin
        mLastWord = mFifo.pop_front();
        expQ.push_back(mLastWord);
      end
      if (mEmit) begin
        mWord = (mWord << 1) | WIDTH'(mEbit);
        mBits++;
        if (mBits == WIDTH) begin
          if (mSize < FIFO_DEPTH) mFifo.push_back(mWord);
          mWord = '0; mBits = 0;
        end
      end
      if (mTrip) begin
        mFail = 1; mFifo.delete(); mWord = '0; mBits = 0; mHavePair = 0;
      end
    end
  end

  // Monitor: every ready pulse must match the oldest predicted delivery.
  always @(negedge clk) begin
    if (monEn) begin
      checkOutput("ready vs model", WIDTH'(bus.ready), WIDTH'(mDeliver));
      if (bus.ready) begin
        if (expQ.size() == 0) begin
          checks++; failures++;
          $display("[TB] FAIL unexpected ready: got word 0x%0h expected no delivery", bus.random_number);
        end else begin
          checkOutput("delivered word", bus.random_number, expQ.pop_front());
        end
      end
      checkOutput("held random_number", bus.random_number, mLastWord);
      checkOutput("fifo_level vs model", WIDTH'(bus.fifo_level), WIDTH'(mFifo.size()));
      checkOutput("health_fail vs model", WIDTH'(bus.health_fail), WIDTH'(mFail));
    end
  end

  task automatic applyStimulus(input bit valid, input bit bitVal);
    @(posedge clk); #1;
    bus.entropy_valid = valid;
    bus.entropy_bit = bitVal;
  endtask

  task automatic sendWord(input logic [WIDTH-1:0] w);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      applyStimulus(1'b1, w[i]);
      applyStimulus(1'b1, !w[i]);
    end
    applyStimulus(1'b0, 1'b0);
  endtask

  task automatic waitReady(input int budget, output bit got, output logic [WIDTH-1:0] word,
                           output int cycles);
    got = 0; word = '0; cycles = 0;
    for (int i = 0; i < budget && !got; i++) begin
      @(posedge clk); #1;
      cycles = i + 1;
      if (bus.ready) begin got = 1; word = bus.random_number; end
    end
  endtask

  task automatic requestWord(input int budget, output bit got, output logic [WIDTH-1:0] word,
                             output int cycles);
    @(posedge clk); #1;
    bus.trng_request = 1'b1;
    waitReady(budget, got, word, cycles);
    bus.trng_request = 1'b0;
  endtask

  task automatic resetDut();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " ready"}, WIDTH'(bus.ready), '0);
    checkOutput({tag, " random_number"}, bus.random_number, '0);
    checkOutput({tag, " health_fail"}, WIDTH'(bus.health_fail), '0);
    checkOutput({tag, " fifo_level"}, WIDTH'(bus.fifo_level), '0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit got;
    logic [WIDTH-1:0] w;
    int cyc;
    logic [WIDTH-1:0] wordB;
    bus.entropy_bit = 1'b0;
    bus.entropy_valid = 1'b0;
    bus.trng_request = 1'b0;

    resetDut();
    monEn = 1'b1;
    @(negedge clk);
    checkAllZero("reset");

    // Alternating (0,1),(1,0) pairs pack to 0x55555555; ready one cycle after request.
    sendWord(32'h5555_5555);
    @(negedge clk);
    checkOutput("pattern level", WIDTH'(bus.fifo_level), WIDTH'(1));
    requestWord(20, got, w, cyc);
    checkOutput("pattern got", WIDTH'(got), WIDTH'(1));
    checkOutput("pattern word", w, 32'h5555_5555);
    checkOutput("pattern latency", WIDTH'(cyc), WIDTH'(1));
    @(posedge clk); #1;
    checkOutput("pattern ready width", WIDTH'(bus.ready), '0);

    // Equal pairs are discarded and add no bits.
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b1, 1'b1);
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b1, (i % 2) == 1);
      applyStimulus(1'b1, (i % 2) == 1);
    end
    applyStimulus(1'b0, 1'b0);
    @(negedge clk);
    checkOutput("discard level", WIDTH'(bus.fifo_level), WIDTH'(1));
    requestWord(20, got, w, cyc);
    checkOutput("discard word", w, 32'hFFFF_FFFF);

    // Request while empty: ready lands two cycles after the final raw bit's valid cycle.
    fork
      begin
        requestWord(500, got, w, cyc);
      end
      begin
        sendWord(32'hA5C3_0F96);
        @(posedge clk); #1;
        checkOutput("empty latency ready", WIDTH'(bus.ready), WIDTH'(1));
      end
    join
    checkOutput("empty request word", w, 32'hA5C3_0F96);

    // Overflow: fifth word is dropped.
    for (int k = 1; k <= 5; k++) sendWord(WIDTH'(k));
    @(negedge clk);
    checkOutput("overflow level", WIDTH'(bus.fifo_level), WIDTH'(FIFO_DEPTH));
    for (int k = 1; k <= 4; k++) begin
      requestWord(20, got, w, cyc);
      checkOutput("overflow word", w, WIDTH'(k));
    end
    @(negedge clk);
    checkOutput("overflow drained", WIDTH'(bus.fifo_level), '0);

    // Push and pop on the same edge at level 1.
    wordB = 32'h0F0F_3C3C;
    sendWord(32'h1234_ABCD);
    for (int i = WIDTH - 1; i >= 1; i--) begin
      applyStimulus(1'b1, wordB[i]);
      applyStimulus(1'b1, !wordB[i]);
    end
    applyStimulus(1'b1, wordB[0]);
    applyStimulus(1'b1, !wordB[0]);
    bus.trng_request = 1'b1;
    applyStimulus(1'b0, 1'b0);
    @(negedge clk);
    bus.trng_request = 1'b0;
    checkOutput("pushpop level", WIDTH'(bus.fifo_level), WIDTH'(1));
    checkOutput("pushpop ready", WIDTH'(bus.ready), WIDTH'(1));
    checkOutput("pushpop older word", bus.random_number, 32'h1234_ABCD);
    requestWord(20, got, w, cyc);
    checkOutput("pushpop newer word", w, wordB);

    // Reset with two words buffered clears everything.
    sendWord(32'hCAFE_0001);
    sendWord(32'hCAFE_0002);
    @(negedge clk);
    checkOutput("prereset level", WIDTH'(bus.fifo_level), WIDTH'(2));
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    checkAllZero("midreset");

    // Randomized entropy and requests, checked by the monitor.
    fork
      begin
        while (!stopFeed) applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      begin
        for (int n = 0; n < 8; n++) begin
          repeat ($urandom_range(0, 300)) @(posedge clk);
          requestWord(3000, got, w, cyc);
          checkOutput("random got", WIDTH'(got), WIDTH'(1));
        end
        stopFeed = 1'b1;
      end
    join
    applyStimulus(1'b0, 1'b0);

    // Health test: RUN_LIMIT identical bits trip a sticky failure and flush the FIFO.
    resetDut();
    sendWord(32'hDEAD_BEEF);
    @(negedge clk);
    checkOutput("health prefill level", WIDTH'(bus.fifo_level), WIDTH'(1));
    applyStimulus(1'b1, 1'b0);
    repeat (RUN_LIMIT - 1) applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1);
    @(negedge clk);
    checkOutput("health before limit", WIDTH'(bus.health_fail), '0);
    applyStimulus(1'b0, 1'b0);
    @(negedge clk);
    checkOutput("health tripped", WIDTH'(bus.health_fail), WIDTH'(1));
    checkOutput("health flush level", WIDTH'(bus.fifo_level), '0);
    sendWord(32'h1357_2468);
    requestWord(40, got, w, cyc);
    checkOutput("health no ready", WIDTH'(got), '0);
    checkOutput("health sticky", WIDTH'(bus.health_fail), WIDTH'(1));

    repeat (3) @(posedge clk);
    checkOutput("scoreboard drained", WIDTH'(expQ.size()), '0);
    monEn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
